// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types for the two-master bus arbiter
// Purpose: arbiter FSM state encoding, bus command struct and a command builder.
// Ports: none (package).
package bus_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_DONE} arb_state_t;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] write_data;
    logic [3:0]  byte_enable;
    logic        read_enable;
    logic        write_enable;
  } bus_cmd_t;

  // Write wins when a master raises both enables, so the read strobe is masked.
  function automatic bus_cmd_t make_cmd(input logic [31:0] address,
                                        input logic [31:0] write_data,
                                        input logic [3:0]  byte_enable,
                                        input logic        read_enable,
                                        input logic        write_enable);
    bus_cmd_t cmd;
    cmd.address      = address;
    cmd.write_data   = write_data;
    cmd.byte_enable  = byte_enable;
    cmd.read_enable  = read_enable & ~write_enable;
    cmd.write_enable = write_enable;
    return cmd;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - master-side and slave-side signals of the bus arbiter
// Purpose: bundles both master ports, the slave port and grant/busy status.
// Ports: none; modport master is the arbiter's view, modport slave the surrounding system's view.
interface bus_arbiter_if;

  logic [31:0] m0_address;
  logic [31:0] m0_write_data;
  logic [3:0]  m0_byte_enable;
  logic        m0_read_enable;
  logic        m0_write_enable;
  logic [31:0] m0_read_data;
  logic        m0_ready;
  logic        m0_error;

  logic [31:0] m1_address;
  logic [31:0] m1_write_data;
  logic [3:0]  m1_byte_enable;
  logic        m1_read_enable;
  logic        m1_write_enable;
  logic [31:0] m1_read_data;
  logic        m1_ready;
  logic        m1_error;

  logic [31:0] bus_address;
  logic [31:0] bus_write_data;
  logic [3:0]  bus_byte_enable;
  logic        bus_read_enable;
  logic        bus_write_enable;
  logic [31:0] bus_read_data;
  logic        bus_ready;

  logic        grant;
  logic        busy;

  modport master (
    input  m0_address, m0_write_data, m0_byte_enable, m0_read_enable, m0_write_enable,
    output m0_read_data, m0_ready, m0_error,
    input  m1_address, m1_write_data, m1_byte_enable, m1_read_enable, m1_write_enable,
    output m1_read_data, m1_ready, m1_error,
    output bus_address, bus_write_data, bus_byte_enable, bus_read_enable, bus_write_enable,
    input  bus_read_data, bus_ready,
    output grant, busy
  );

  modport slave (
    output m0_address, m0_write_data, m0_byte_enable, m0_read_enable, m0_write_enable,
    input  m0_read_data, m0_ready, m0_error,
    output m1_address, m1_write_data, m1_byte_enable, m1_read_enable, m1_write_enable,
    input  m1_read_data, m1_ready, m1_error,
    input  bus_address, bus_write_data, bus_byte_enable, bus_read_enable, bus_write_enable,
    output bus_read_data, bus_ready,
    input  grant, busy
  );

endinterface

// File: rtl/bus_timeout_counter.sv
// rtl/bus_timeout_counter.sv - wait-cycle counter that flags a hung slave
// Purpose: counts enabled cycles since the last clear; expires on the enabled cycle
//          where the count reaches TIMEOUT_CYCLES-1. TIMEOUT_CYCLES=0 never expires.
// Ports: clock, reset (sync active-low), i_clear, i_enable, o_expired.
module bus_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [W-1:0] LIMIT = (TIMEOUT_CYCLES > 0) ? W'(TIMEOUT_CYCLES - 1) : '0;

  logic [W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (TIMEOUT_CYCLES != 0) && i_enable && (r_count == LIMIT);

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master round-robin arbiter for the 32-bit memory bus
// Purpose: grants one master per transfer, registers the command to the slave,
//          returns a one-cycle registered completion, and forces an error
//          completion when the slave hangs.
// Ports: clock, reset (sync active-low), bus (bus_arbiter_if.master: m0_*, m1_*, bus_*, grant, busy).
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic           clock,
  input logic           reset,
  bus_arbiter_if.master bus
);

  arb_state_t  r_state, w_next;
  bus_cmd_t    r_bus;
  bus_cmd_t    w_m0_cmd, w_m1_cmd;
  logic        r_grant;
  logic        r_m0_ready, r_m1_ready, r_m0_error, r_m1_error;
  logic [31:0] r_m0_read_data, r_m1_read_data;
  logic        w_m0_req, w_m1_req;
  logic        w_grant_valid, w_grant_sel;
  logic        w_complete, w_timeout, w_expired;
  logic [31:0] w_rdata;

  assign w_m0_cmd = make_cmd(bus.m0_address, bus.m0_write_data, bus.m0_byte_enable,
                             bus.m0_read_enable, bus.m0_write_enable);
  assign w_m1_cmd = make_cmd(bus.m1_address, bus.m1_write_data, bus.m1_byte_enable,
                             bus.m1_read_enable, bus.m1_write_enable);
  assign w_m0_req = bus.m0_read_enable | bus.m0_write_enable;
  assign w_m1_req = bus.m1_read_enable | bus.m1_write_enable;

  // Counter is held clear outside BUSY, so every transfer starts from zero.
  bus_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (r_state != ARB_BUSY),
    .i_enable  ((r_state == ARB_BUSY) && !bus.bus_ready),
    .o_expired (w_expired)
  );

  always_ff @(posedge clock) begin
    if (!reset) r_state <= ARB_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_grant_valid = 1'b0;
    w_grant_sel   = r_grant;
    w_complete    = 1'b0;
    w_timeout     = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        // On a tie the master that did not own the last transfer wins.
        if (w_m0_req && w_m1_req) begin
          w_grant_valid = 1'b1;
          w_grant_sel   = ~r_grant;
        end else if (w_m0_req) begin
          w_grant_valid = 1'b1;
          w_grant_sel   = 1'b0;
        end else if (w_m1_req) begin
          w_grant_valid = 1'b1;
          w_grant_sel   = 1'b1;
        end
        if (w_grant_valid) w_next = ARB_BUSY;
      end
      ARB_BUSY: begin
        // A slave response in the expiry cycle beats the timeout.
        if (bus.bus_ready) begin
          w_complete = 1'b1;
          w_next     = ARB_DONE;
        end else if (w_expired) begin
          w_complete = 1'b1;
          w_timeout  = 1'b1;
          w_next     = ARB_DONE;
        end
      end
      ARB_DONE: w_next = ARB_IDLE;
      default:  w_next = ARB_IDLE;
    endcase
  end

  assign w_rdata = (w_timeout || r_bus.write_enable) ? 32'h0 : bus.bus_read_data;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_bus          <= '0;
      r_grant        <= 1'b1;
      r_m0_ready     <= 1'b0;
      r_m1_ready     <= 1'b0;
      r_m0_error     <= 1'b0;
      r_m1_error     <= 1'b0;
      r_m0_read_data <= 32'h0;
      r_m1_read_data <= 32'h0;
    end else begin
      r_m0_ready <= 1'b0;
      r_m1_ready <= 1'b0;
      r_m0_error <= 1'b0;
      r_m1_error <= 1'b0;
      if (w_grant_valid) begin
        r_grant <= w_grant_sel;
        r_bus   <= w_grant_sel ? w_m1_cmd : w_m0_cmd;
      end
      if (w_complete) begin
        r_bus.read_enable  <= 1'b0;
        r_bus.write_enable <= 1'b0;
        if (r_grant) begin
          r_m1_ready     <= 1'b1;
          r_m1_error     <= w_timeout;
          r_m1_read_data <= w_rdata;
        end else begin
          r_m0_ready     <= 1'b1;
          r_m0_error     <= w_timeout;
          r_m0_read_data <= w_rdata;
        end
      end
    end
  end

  assign bus.bus_address      = r_bus.address;
  assign bus.bus_write_data   = r_bus.write_data;
  assign bus.bus_byte_enable  = r_bus.byte_enable;
  assign bus.bus_read_enable  = r_bus.read_enable;
  assign bus.bus_write_enable = r_bus.write_enable;
  assign bus.m0_ready         = r_m0_ready;
  assign bus.m0_error         = r_m0_error;
  assign bus.m0_read_data     = r_m0_read_data;
  assign bus.m1_ready         = r_m1_ready;
  assign bus.m1_error         = r_m1_error;
  assign bus.m1_read_data     = r_m1_read_data;
  assign bus.grant            = r_grant;
  assign bus.busy             = (r_state != ARB_IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
module tb_bus_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  bus_arbiter_if bus_if ();

  bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.m0_address = 0; bus_if.m0_write_data = 0; bus_if.m0_byte_enable = 0;
    bus_if.m0_read_enable = 0; bus_if.m0_write_enable = 0;
    bus_if.m1_address = 0; bus_if.m1_write_data = 0; bus_if.m1_byte_enable = 0;
    bus_if.m1_read_enable = 0; bus_if.m1_write_enable = 0;
    bus_if.bus_read_data = 0; bus_if.bus_ready = 0;
  endtask

  initial begin
    int cnt;
    logic seen;
    idle_inputs();

    // Reset state
    tick(); tick();
    check("rst_re", bus_if.bus_read_enable, 0);
    check("rst_we", bus_if.bus_write_enable, 0);
    check("rst_addr", bus_if.bus_address, 0);
    check("rst_grant", bus_if.grant, 1);
    check("rst_busy", bus_if.busy, 0);
    check("rst_m0_ready", bus_if.m0_ready, 0);
    check("rst_m1_rdata", bus_if.m1_read_data, 0);
    reset = 1'b1;
    tick();

    // m0 read, slave ready on 2nd BUSY cycle
    bus_if.m0_read_enable = 1; bus_if.m0_address = 32'h40;
    tick();
    check("t1_grant", bus_if.grant, 0);
    check("t1_addr", bus_if.bus_address, 32'h40);
    check("t1_re_c1", bus_if.bus_read_enable, 1);
    tick();
    check("t1_re_c2", bus_if.bus_read_enable, 1);
    check("t1_ready_early", bus_if.m0_ready, 0);
    bus_if.bus_ready = 1; bus_if.bus_read_data = 32'hDEADBEEF;
    tick();
    check("t1_m0_ready", bus_if.m0_ready, 1);
    check("t1_m0_rdata", bus_if.m0_read_data, 32'hDEADBEEF);
    check("t1_m0_error", bus_if.m0_error, 0);
    check("t1_m1_ready", bus_if.m1_ready, 0);
    check("t1_re_done", bus_if.bus_read_enable, 0);
    idle_inputs();
    tick();
    check("t1_pulse_end", bus_if.m0_ready, 0);
    check("t1_idle", bus_if.busy, 0);

    // Both masters from reset, slave always ready: alternate 0,1,0,1
    reset = 0; tick(); reset = 1; tick();
    bus_if.m0_read_enable = 1; bus_if.m0_address = 32'h1000;
    bus_if.m1_read_enable = 1; bus_if.m1_address = 32'h2000;
    bus_if.bus_ready = 1; bus_if.bus_read_data = 32'hA5A50000;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("t2_grant%0d", k), bus_if.grant, k % 2);
      check($sformatf("t2_addr%0d", k), bus_if.bus_address, (k % 2) ? 32'h2000 : 32'h1000);
      tick();
      check($sformatf("t2_m0rdy%0d", k), bus_if.m0_ready, (k % 2) ? 0 : 1);
      check($sformatf("t2_m1rdy%0d", k), bus_if.m1_ready, (k % 2) ? 1 : 0);
      tick();
      check($sformatf("t2_idle%0d", k), bus_if.busy, 0);
    end
    idle_inputs();
    tick();

    // m1 read against a hung slave: timeout after 4 BUSY cycles
    bus_if.m1_read_enable = 1; bus_if.m1_address = 32'h300;
    bus_if.bus_read_data = 32'h55555555;
    cnt = 0; seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus_if.bus_read_enable) cnt++;
      if (bus_if.m1_ready) begin seen = 1; break; end
    end
    check("t3_re_cycles", cnt, 4);
    check("t3_m1_ready", seen, 1);
    check("t3_m1_error", bus_if.m1_error, 1);
    check("t3_m1_rdata", bus_if.m1_read_data, 0);
    idle_inputs();
    tick();
    check("t3_idle", bus_if.busy, 0);

    // m0 write, slave ready on 3rd BUSY cycle
    bus_if.m0_write_enable = 1; bus_if.m0_address = 32'h100;
    bus_if.m0_write_data = 32'h12345678; bus_if.m0_byte_enable = 4'b0011;
    bus_if.bus_read_data = 32'hFFFF0000;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("t4_addr%0d", c), bus_if.bus_address, 32'h100);
      check($sformatf("t4_wdata%0d", c), bus_if.bus_write_data, 32'h12345678);
      check($sformatf("t4_be%0d", c), bus_if.bus_byte_enable, 4'b0011);
      check($sformatf("t4_we%0d", c), bus_if.bus_write_enable, 1);
      check($sformatf("t4_re%0d", c), bus_if.bus_read_enable, 0);
    end
    bus_if.bus_ready = 1;
    tick();
    check("t4_m0_ready", bus_if.m0_ready, 1);
    check("t4_m0_rdata", bus_if.m0_read_data, 0);
    check("t4_we_done", bus_if.bus_write_enable, 0);
    idle_inputs();
    tick();

    // Reset in the middle of an m1 transfer
    bus_if.m1_read_enable = 1; bus_if.m1_address = 32'h500;
    tick();
    check("t5_busy", bus_if.busy, 1);
    check("t5_grant_m1", bus_if.grant, 1);
    reset = 0;
    tick();
    check("t5_rst_re", bus_if.bus_read_enable, 0);
    check("t5_rst_busy", bus_if.busy, 0);
    check("t5_rst_grant", bus_if.grant, 1);
    check("t5_rst_m1rdy", bus_if.m1_ready, 0);
    reset = 1;
    bus_if.m0_read_enable = 1; bus_if.m0_address = 32'h600;
    tick();
    check("t5_first_m0", bus_if.grant, 0);
    bus_if.bus_ready = 1; bus_if.bus_read_data = 32'h0BADF00D;
    tick();
    check("t5_m0_ready", bus_if.m0_ready, 1);
    check("t5_m1_ready", bus_if.m1_ready, 0);
    idle_inputs();
    tick();

    // Read and write together: write wins
    bus_if.m0_read_enable = 1; bus_if.m0_write_enable = 1; bus_if.m0_address = 32'h680;
    tick();
    check("t6_we", bus_if.bus_write_enable, 1);
    check("t6_re", bus_if.bus_read_enable, 0);
    bus_if.bus_ready = 1;
    tick();
    check("t6_ready", bus_if.m0_ready, 1);
    idle_inputs();
    tick();

    // bus_ready coincides with timeout expiry: normal completion
    bus_if.m0_read_enable = 1; bus_if.m0_address = 32'h700;
    bus_if.bus_read_data = 32'hCAFEF00D;
    tick(); tick(); tick(); tick();
    check("t7_still_busy", bus_if.bus_read_enable, 1);
    bus_if.bus_ready = 1;
    tick();
    check("t7_ready", bus_if.m0_ready, 1);
    check("t7_error", bus_if.m0_error, 0);
    check("t7_rdata", bus_if.m0_read_data, 32'hCAFEF00D);
    idle_inputs();
    tick();
    check("t7_idle", bus_if.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
